// File: rtl/dbg_trigger_if.sv
// Bus bundle between the core and dbg_trigger_unit: CSR port, compare inputs, fire outputs.
// Handshake: there is no backpressure. Each *_valid qualifies its address for the cycle it is
// high, csr_we is a one-cycle strobe, and trig_bp/trig_dbg are one-cycle pulses.
interface dbg_trigger_if #(
    parameter int XLEN  = 32,
    parameter int NTRIG = 4
);
    localparam int TW = $clog2(NTRIG);

    logic            csr_we;
    logic [TW-1:0]   csr_sel;
    logic            csr_is_td2;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            dbg_mode;
    logic            priv_m;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ld_valid;
    logic [XLEN-1:0] ld_addr;
    logic            st_valid;
    logic [XLEN-1:0] st_addr;
    logic            retire;
    logic            flush;
    logic            trig_bp;
    logic            trig_dbg;
    logic [TW-1:0]   trig_idx;

    modport master (
        output csr_we, csr_sel, csr_is_td2, csr_wdata, dbg_mode, priv_m,
               ex_valid, ex_pc, ld_valid, ld_addr, st_valid, st_addr, retire, flush,
        input  csr_rdata, trig_bp, trig_dbg, trig_idx
    );

    modport slave (
        input  csr_we, csr_sel, csr_is_td2, csr_wdata, dbg_mode, priv_m,
               ex_valid, ex_pc, ld_valid, ld_addr, st_valid, st_addr, retire, flush,
        output csr_rdata, trig_bp, trig_dbg, trig_idx
    );
endinterface

// File: rtl/dbg_trigger_unit.sv
// NTRIG mcontrol-style breakpoint/watchpoint triggers with chaining and sticky hit bits.
// Optional: define DBG_TRIG_ICOUNT_EN to turn trigger NTRIG-1 into an icount trigger.
module dbg_trigger_unit #(
    parameter int XLEN  = 32,
    parameter int NTRIG = 4
) (
    input logic          clock,
    input logic          reset_n,
    dbg_trigger_if.slave bus
);
    localparam int TW = $clog2(NTRIG);
    localparam logic [NTRIG-1:0] LAST_MASK = NTRIG'(1) << (NTRIG - 1);
`ifdef DBG_TRIG_ICOUNT_EN
    localparam logic [NTRIG-1:0] IC_MASK = LAST_MASK;
`else
    localparam logic [NTRIG-1:0] IC_MASK = '0;
`endif
    localparam logic [NTRIG-1:0] MATCH_MASK = ~IC_MASK;
    localparam logic [NTRIG-1:0] CHAIN_MASK = ~LAST_MASK & MATCH_MASK;

    logic [NTRIG-1:0]            dmode_q, hit_q, action_q, chain_q;
    logic [NTRIG-1:0]            m_q, u_q, x_q, st_q, ld_q;
    logic [NTRIG-1:0][1:0]       match_q;
    logic [NTRIG-1:0][XLEN-1:0]  tdata2_q;

    logic [NTRIG-1:0] wr_td1, wr_td2, priv_ok;
    logic [NTRIG-1:0] mt_ex, mt_ld, mt_st;
    logic [NTRIG-1:0] grp_c, hit_grp, hit_set;
    logic [2:0]       acc_c;
    logic             fire_c, ic_fire;
    logic [TW-1:0]    win_c;

    function automatic logic addr_hit(input logic [1:0] code, input logic [XLEN-1:0] addr,
                                      input logic [XLEN-1:0] tdata2);
        logic [XLEN-1:0] mask;
        int k;
        k = 0;
        for (int b = 0; b < XLEN - 2; b++)
            if (tdata2[b] && k == b) k = b + 1;
        mask = {XLEN{1'b1}} << (k + 1);
        case (code)
            2'd0:    addr_hit = (addr == tdata2);
            2'd1:    addr_hit = ((addr & mask) == (tdata2 & mask));
            2'd2:    addr_hit = (addr >= tdata2);
            default: addr_hit = (addr < tdata2);
        endcase
    endfunction

    // A trigger whose dmode is set belongs to the debugger: only debug mode may touch it.
    always_comb begin
        wr_td1 = '0;
        wr_td2 = '0;
        for (int i = 0; i < NTRIG; i++) begin
            if (bus.csr_we && int'(bus.csr_sel) == i && (!dmode_q[i] || bus.dbg_mode)) begin
                wr_td1[i] = !bus.csr_is_td2;
                wr_td2[i] = bus.csr_is_td2;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dmode_q  <= '0;
            hit_q    <= '0;
            action_q <= '0;
            chain_q  <= '0;
            m_q      <= '0;
            u_q      <= '0;
            x_q      <= '0;
            st_q     <= '0;
            ld_q     <= '0;
            match_q  <= '0;
            tdata2_q <= '0;
        end else begin
            for (int i = 0; i < NTRIG; i++) begin
                if (wr_td1[i]) begin
                    dmode_q[i]  <= bus.csr_wdata[27] & bus.dbg_mode;
                    action_q[i] <= bus.csr_wdata[12] & MATCH_MASK[i];
                    chain_q[i]  <= bus.csr_wdata[11] & CHAIN_MASK[i];
                    match_q[i]  <= bus.csr_wdata[8:7] & {2{MATCH_MASK[i]}};
                    m_q[i]      <= bus.csr_wdata[6];
                    u_q[i]      <= bus.csr_wdata[3];
                    x_q[i]      <= bus.csr_wdata[2] & MATCH_MASK[i];
                    st_q[i]     <= bus.csr_wdata[1] & MATCH_MASK[i];
                    ld_q[i]     <= bus.csr_wdata[0] & MATCH_MASK[i];
                end
                if (wr_td2[i]) tdata2_q[i] <= bus.csr_wdata;
                // A hardware hit beats a same-cycle CSR write of the hit bit.
                hit_q[i] <= hit_set[i] | (wr_td1[i] ? bus.csr_wdata[20] : hit_q[i]);
            end
        end
    end

`ifdef DBG_TRIG_ICOUNT_EN
    logic [13:0] count_q;
    logic        ic_armed, ic_dec;

    assign ic_armed = bus.priv_m ? m_q[NTRIG-1] : u_q[NTRIG-1];
    assign ic_dec   = bus.retire && ic_armed && !bus.dbg_mode && (count_q != 14'd0);
    assign ic_fire  = ic_dec && (count_q == 14'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                count_q <= '0;
        else if (wr_td1[NTRIG-1])    count_q <= bus.csr_wdata[23:10];
        else if (ic_dec)             count_q <= count_q - 14'd1;
    end
`else
    assign ic_fire = 1'b0;
`endif

    always_comb begin
        bus.csr_rdata = '0;
        for (int i = 0; i < NTRIG; i++) begin
            if (int'(bus.csr_sel) == i) begin
                if (bus.csr_is_td2) begin
                    bus.csr_rdata = tdata2_q[i];
                end else begin
                    bus.csr_rdata[31:28] = IC_MASK[i] ? 4'd3 : 4'd2;
                    bus.csr_rdata[27]    = dmode_q[i];
                    bus.csr_rdata[20]    = hit_q[i];
                    bus.csr_rdata[12]    = action_q[i];
                    bus.csr_rdata[11]    = chain_q[i];
                    bus.csr_rdata[8:7]   = match_q[i];
                    bus.csr_rdata[6]     = m_q[i];
                    bus.csr_rdata[3]     = u_q[i];
                    bus.csr_rdata[2]     = x_q[i];
                    bus.csr_rdata[1]     = st_q[i];
                    bus.csr_rdata[0]     = ld_q[i];
`ifdef DBG_TRIG_ICOUNT_EN
                    if (IC_MASK[i]) bus.csr_rdata[23:10] = count_q;
`endif
                end
            end
        end
    end

    always_comb begin
        priv_ok = '0;
        mt_ex   = '0;
        mt_ld   = '0;
        mt_st   = '0;
        for (int i = 0; i < NTRIG; i++) begin
            priv_ok[i] = bus.priv_m ? m_q[i] : u_q[i];
            mt_ex[i] = bus.ex_valid && x_q[i] && priv_ok[i] &&
                       addr_hit(match_q[i], bus.ex_pc, tdata2_q[i]);
            mt_ld[i] = bus.ld_valid && ld_q[i] && priv_ok[i] &&
                       addr_hit(match_q[i], bus.ld_addr, tdata2_q[i]);
            mt_st[i] = bus.st_valid && st_q[i] && priv_ok[i] &&
                       addr_hit(match_q[i], bus.st_addr, tdata2_q[i]);
        end
    end

    // Walk groups in index order; acc_c keeps, per access type, whether every member so far matched.
    always_comb begin
        acc_c   = 3'b111;
        grp_c   = '0;
        fire_c  = 1'b0;
        win_c   = '0;
        hit_grp = '0;
        for (int i = 0; i < NTRIG; i++) begin
            acc_c    = acc_c & {mt_st[i], mt_ld[i], mt_ex[i]};
            grp_c[i] = 1'b1;
            if (!chain_q[i]) begin
                if (!fire_c && acc_c != 3'b000) begin
                    fire_c  = 1'b1;
                    win_c   = TW'(i);
                    hit_grp = grp_c;
                end
                acc_c = 3'b111;
                grp_c = '0;
            end
        end
        if (bus.flush || bus.dbg_mode) begin
            fire_c  = 1'b0;
            hit_grp = '0;
        end
    end

    assign hit_set = hit_grp | (IC_MASK & {NTRIG{ic_fire && !fire_c}});

    // icount has no action field of its own, so it always raises a breakpoint.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.trig_bp  <= 1'b0;
            bus.trig_dbg <= 1'b0;
            bus.trig_idx <= '0;
        end else if (fire_c) begin
            bus.trig_bp  <= ~action_q[win_c];
            bus.trig_dbg <= action_q[win_c];
            bus.trig_idx <= win_c;
        end else if (ic_fire) begin
            bus.trig_bp  <= 1'b1;
            bus.trig_dbg <= 1'b0;
            bus.trig_idx <= TW'(NTRIG - 1);
        end else begin
            bus.trig_bp  <= 1'b0;
            bus.trig_dbg <= 1'b0;
            bus.trig_idx <= '0;
        end
    end
endmodule

// File: tb/tb_dbg_trigger_unit.sv
// Bench for dbg_trigger_unit: directed scenarios, then random traffic against a word-level model.
module tb_dbg_trigger_unit;
    localparam int XLEN  = 32;
    localparam int NTRIG = 4;
    localparam int TW    = $clog2(NTRIG);
    localparam logic [31:0] TD1_RESET = 32'h2000_0000;
    localparam logic [31:0] TD1_WMASK = 32'h0810_19CF;
    localparam int K_LD = 0, K_ST = 1, K_EX = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    dbg_trigger_if #(.XLEN(XLEN), .NTRIG(NTRIG)) bus ();

    dbg_trigger_unit #(.XLEN(XLEN), .NTRIG(NTRIG)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_td1 [NTRIG];
    logic [31:0] m_td2 [NTRIG];
    logic [31:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_word();
        return {22'b0, bus.trig_bp, bus.trig_dbg, 8'(bus.trig_idx)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NTRIG; i++) begin
            m_td1[i] = TD1_RESET;
            m_td2[i] = '0;
        end
        exp_q.delete();
    endtask

    function automatic int ones_below(input logic [31:0] v);
        int k;
        k = 0;
        while (k < XLEN - 2 && v[k]) k++;
        return k;
    endfunction

    function automatic bit addr_ok(input logic [31:0] td1, input logic [31:0] td2,
                                   input logic [31:0] a);
        longint unsigned blk;
        case (td1[8:7])
            2'd0: return (a == td2);
            2'd1: begin
                blk = 64'd1 << (ones_below(td2) + 1);
                return ((64'(a) / blk) == (64'(td2) / blk));
            end
            2'd2: return (a >= td2);
            default: return (a < td2);
        endcase
    endfunction

    function automatic bit trig_ok(input int i, input int kind, input logic [31:0] a, input bit pm);
        bit priv_ok;
        priv_ok = pm ? m_td1[i][6] : m_td1[i][3];
        return m_td1[i][kind] && priv_ok && addr_ok(m_td1[i], m_td2[i], a);
    endfunction

    task automatic model_write(input int sel, input bit td2, input logic [31:0] w, input bit dm);
        logic [31:0] nv;
        if (m_td1[sel][27] && !dm) return;
        if (td2) begin
            m_td2[sel] = w;
        end else begin
            nv = TD1_RESET | (w & TD1_WMASK);
            if (!dm) nv[27] = 1'b0;
            if (sel == NTRIG - 1) nv[11] = 1'b0;
            m_td1[sel] = nv;
        end
    endtask

    // One clock: predict from pre-edge state and current inputs, update model, check after edge.
    task automatic tick();
        logic [31:0] addr [3];
        bit          vld [3];
        bit          fired, all_ok;
        int          widx, first;
        logic [31:0] hits, exp_out;
        fired = 0; widx = 0; first = 0; hits = '0; exp_out = '0;
        addr[K_LD] = bus.ld_addr; vld[K_LD] = bus.ld_valid;
        addr[K_ST] = bus.st_addr; vld[K_ST] = bus.st_valid;
        addr[K_EX] = bus.ex_pc;   vld[K_EX] = bus.ex_valid;
        if (!bus.flush && !bus.dbg_mode) begin
            for (int i = 0; i < NTRIG; i++) begin
                if (!m_td1[i][11] || i == NTRIG - 1) begin
                    for (int kind = 0; kind < 3; kind++) begin
                        all_ok = vld[kind];
                        for (int j = first; j <= i; j++)
                            all_ok = all_ok && trig_ok(j, kind, addr[kind], bus.priv_m);
                        if (all_ok && !fired) begin
                            fired = 1;
                            widx  = i;
                            for (int j = first; j <= i; j++) hits[j] = 1'b1;
                        end
                    end
                    first = i + 1;
                end
            end
        end
        if (fired) exp_out = (m_td1[widx][12] ? 32'h100 : 32'h200) | 32'(widx);
        exp_q.push_back(exp_out);
        if (bus.csr_we) model_write(int'(bus.csr_sel), bus.csr_is_td2, bus.csr_wdata, bus.dbg_mode);
        for (int i = 0; i < NTRIG; i++)
            if (hits[i]) m_td1[i][20] = 1'b1;
        @(posedge clock);
        #1;
        check_val("trig_out", out_word(), exp_q.pop_front());
        @(negedge clock);
    endtask

    task automatic drive_idle();
        bus.csr_we = 0; bus.csr_sel = '0; bus.csr_is_td2 = 0; bus.csr_wdata = '0;
        bus.dbg_mode = 0; bus.priv_m = 1; bus.retire = 0; bus.flush = 0;
        bus.ex_valid = 0; bus.ex_pc = '0; bus.ld_valid = 0; bus.ld_addr = '0;
        bus.st_valid = 0; bus.st_addr = '0;
    endtask

    task automatic csr_write(input int sel, input bit td2, input logic [31:0] w);
        bus.csr_we = 1; bus.csr_sel = TW'(sel); bus.csr_is_td2 = td2; bus.csr_wdata = w;
        tick();
        bus.csr_we = 0;
    endtask

    task automatic access(input int kind, input logic [31:0] a);
        case (kind)
            K_LD: begin bus.ld_valid = 1; bus.ld_addr = a; end
            K_ST: begin bus.st_valid = 1; bus.st_addr = a; end
            default: begin bus.ex_valid = 1; bus.ex_pc = a; end
        endcase
        tick();
        bus.ld_valid = 0; bus.st_valid = 0; bus.ex_valid = 0;
    endtask

    task automatic check_rd(input int sel, input bit td2, input string tag);
        bus.csr_sel = TW'(sel); bus.csr_is_td2 = td2;
        #1;
        check_val(tag, bus.csr_rdata, td2 ? m_td2[sel] : m_td1[sel]);
    endtask

    task automatic check_rd_lit(input int sel, input bit td2, input logic [31:0] exp,
                                input string tag);
        bus.csr_sel = TW'(sel); bus.csr_is_td2 = td2;
        #1;
        check_val(tag, bus.csr_rdata, exp);
    endtask

    function automatic logic [31:0] near_addr();
        logic [31:0] base;
        base = m_td2[$urandom_range(0, NTRIG - 1)];
        return base + 32'($urandom_range(0, 64)) - 32'd32;
    endfunction

    initial begin
        logic [31:0] pool [5];
        logic [31:0] w;
        pool[0] = 32'h0000_1000; pool[1] = 32'h0000_2000; pool[2] = 32'h8000_0100;
        pool[3] = 32'h2000_00FF; pool[4] = 32'h0000_13FF;

        drive_idle();
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("rst_out", out_word(), 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < NTRIG; i++) begin
            check_rd_lit(i, 0, 32'h2000_0000, "rst_td1");
            check_rd_lit(i, 1, 32'h0, "rst_td2");
        end

        // Exact PC breakpoint, M vs U.
        csr_write(0, 1, 32'h8000_0100);
        csr_write(0, 0, 32'h0000_0044);
        access(K_EX, 32'h8000_0100);
        check_rd_lit(0, 0, 32'h2010_0044, "t0_hit");
        bus.priv_m = 0;
        access(K_EX, 32'h8000_0100);
        bus.priv_m = 1;

        // NAPOT store watchpoint over 512 bytes.
        csr_write(1, 1, 32'h2000_00FF);
        csr_write(1, 0, 32'h0000_00C2);
        access(K_ST, 32'h2000_01FC);
        access(K_ST, 32'h2000_0200);
        check_rd_lit(1, 0, 32'h2010_00C2, "t1_hit");

        // Chained range on loads.
        csr_write(2, 1, 32'h0000_1000);
        csr_write(2, 0, 32'h0000_0941);
        csr_write(3, 1, 32'h0000_2000);
        csr_write(3, 0, 32'h0000_11C1);
        access(K_LD, 32'h0000_1800);
        check_rd_lit(2, 0, 32'h2010_0941, "t2_hit");
        check_rd_lit(3, 0, 32'h2010_11C1, "t3_hit");
        access(K_LD, 32'h0000_2000);

        // Flush suppression, then priority with both T0 and T1 matching.
        csr_write(0, 0, 32'h0000_0044);
        csr_write(1, 0, 32'h0000_00C2);
        bus.flush = 1; bus.ex_valid = 1; bus.ex_pc = 32'h8000_0100;
        bus.st_valid = 1; bus.st_addr = 32'h2000_0100;
        tick();
        check_rd_lit(0, 0, 32'h2000_0044, "flush_t0");
        check_rd_lit(1, 0, 32'h2000_00C2, "flush_t1");
        bus.flush = 0;
        tick();
        bus.ex_valid = 0; bus.st_valid = 0;
        check_rd_lit(0, 0, 32'h2010_0044, "prio_t0");
        check_rd_lit(1, 0, 32'h2000_00C2, "prio_t1");

        // dmode handling.
        bus.priv_m = 0;
        csr_write(0, 0, 32'h0800_0044);
        check_rd_lit(0, 0, 32'h2000_0044, "dmode_u");
        bus.dbg_mode = 1;
        csr_write(0, 0, 32'h0800_0044);
        bus.dbg_mode = 0;
        csr_write(0, 0, 32'h0000_0000);
        csr_write(0, 1, 32'h0000_1234);
        check_rd_lit(0, 0, 32'h2800_0044, "dmode_lock1");
        check_rd_lit(0, 1, 32'h8000_0100, "dmode_lock2");
        bus.dbg_mode = 1;
        access(K_EX, 32'h8000_0100);
        csr_write(0, 0, 32'h0000_0044);
        bus.dbg_mode = 0;
        check_rd(0, 0, "dmode_unlock");

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            bus.priv_m     = 1'($urandom_range(0, 1));
            bus.dbg_mode   = ($urandom_range(0, 7) == 0);
            bus.flush      = ($urandom_range(0, 7) == 0);
            bus.retire     = 1'($urandom_range(0, 1));
            bus.csr_we     = ($urandom_range(0, 3) == 0);
            bus.csr_sel    = TW'($urandom_range(0, NTRIG - 1));
            bus.csr_is_td2 = 1'($urandom_range(0, 1));
            if (bus.csr_is_td2) begin
                w = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 4)];
            end else begin
                w = $urandom();
                if ($urandom_range(0, 15) != 0) w[27] = 1'b0;
            end
            bus.csr_wdata = w;
            bus.ex_valid = 1'($urandom_range(0, 1)); bus.ex_pc   = near_addr();
            bus.ld_valid = 1'($urandom_range(0, 1)); bus.ld_addr = near_addr();
            bus.st_valid = 1'($urandom_range(0, 1)); bus.st_addr = near_addr();
            tick();
            bus.csr_we = 0;
            check_rd($urandom_range(0, NTRIG - 1), 1'($urandom_range(0, 1)), "rand_rd");
        end

        // Reset while a fire is pending.
        drive_idle();
        bus.dbg_mode = 1;
        csr_write(0, 0, 32'h0000_0044);
        bus.dbg_mode = 0;
        csr_write(0, 1, 32'h8000_0100);
        bus.ex_valid = 1; bus.ex_pc = 32'h8000_0100;
        #2 reset_n = 1'b0;
        @(posedge clock);
        #1;
        check_val("rst_mid_out", out_word(), 32'h0);
        model_reset();
        @(negedge clock);
        drive_idle();
        reset_n = 1'b1;
        check_rd_lit(0, 0, 32'h2000_0000, "rst_mid_td1");
        check_rd_lit(0, 1, 32'h0, "rst_mid_td2");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
